// File: rtl/srlzr_tx_sched.sv
// Round-robin scheduler sharing one PISO serializer among NUM_REQ byte sources.
// Grants a requester, loads its word, paces DATA_WIDTH shift strobes, then holds an inter-frame gap.
module srlzr_tx_sched #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          ser_load,
    output logic [DATA_WIDTH-1:0]         ser_data,
    output logic                          ser_shift,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CW     = ID_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NUM_REQ - 1);
    localparam logic [CW-1:0]     NUM_REQ_C = CW'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t                  state_q;
    logic [ID_W-1:0]         rr_ptr_q;
    logic [ID_W-1:0]         grant_id_q;
    logic [BAUD_W-1:0]       baud_q;
    logic [BIT_W-1:0]        bit_q;
    logic [GAP_W-1:0]        gap_q;
    logic [NUM_REQ-1:0]      req_ready_q;
    logic                    ser_load_q;
    logic [DATA_WIDTH-1:0]   ser_data_q;
    logic                    ser_shift_q;
    logic                    busy_q;

    logic [ID_W-1:0]         pick_id_d;
    logic                    pick_found_d;
    logic [ID_W-1:0]         rr_ptr_d;
    logic [DATA_WIDTH-1:0]   req_word [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        logic [CW-1:0] cand;
        pick_found_d = 1'b0;
        pick_id_d    = rr_ptr_q;
        cand         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + CW'(i);
            if (cand >= NUM_REQ_C) begin
                cand = cand - NUM_REQ_C;
            end
            if (!pick_found_d && req_valid[cand[ID_W-1:0]]) begin
                pick_found_d = 1'b1;
                pick_id_d    = cand[ID_W-1:0];
            end
        end
    end

    assign rr_ptr_d = (grant_id_q == ID_LAST) ? '0 : grant_id_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            req_ready_q <= '0;
            ser_load_q  <= 1'b0;
            ser_data_q  <= '0;
            ser_shift_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle so every assertion below is a single-cycle pulse.
            req_ready_q <= '0;
            ser_load_q  <= 1'b0;
            ser_shift_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (en && pick_found_d) begin
                        grant_id_q <= pick_id_d;
                        state_q    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    busy_q <= 1'b1;
                    if (req_valid[grant_id_q]) begin
                        req_ready_q[grant_id_q] <= 1'b1;
                        ser_load_q              <= 1'b1;
                        ser_data_q              <= req_word[grant_id_q];
                        rr_ptr_q                <= rr_ptr_d;
                        baud_q                  <= '0;
                        bit_q                   <= '0;
                        state_q                 <= ST_SHIFT;
                    end else begin
                        // Requester withdrew between grant and load: re-arbitrate without advancing rr_ptr.
                        state_q <= ST_IDLE;
                    end
                end

                ST_SHIFT: begin
                    busy_q <= 1'b1;
                    if (baud_q == BAUD_LAST) begin
                        baud_q      <= '0;
                        ser_shift_q <= 1'b1;
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
                            gap_q   <= '0;
                            state_q <= ST_GAP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                ST_GAP: begin
                    busy_q <= 1'b1;
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign ser_load  = ser_load_q;
    assign ser_data  = ser_data_q;
    assign ser_shift = ser_shift_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_q));
    a_load_with_ready: assert property (@(posedge clk) disable iff (rst) ser_load_q == (req_ready_q != '0));
`endif

endmodule

// File: tb/tb_srlzr_tx_sched.sv
// Bench for srlzr_tx_sched: directed scenarios plus random traffic, every cycle compared
// against a timeline model built from grant/load/shift/gap cycle arithmetic.
module tb_srlzr_tx_sched;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int CPB = 4;
    localparam int GAP = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data  = '0;
    logic [NR-1:0]     req_ready;
    logic              ser_load;
    logic [DW-1:0]     ser_data;
    logic              ser_shift;
    logic [1:0]        grant_id;
    logic              busy;

    srlzr_tx_sched #(
        .DATA_WIDTH  (DW),
        .NUM_REQ     (NR),
        .CLKS_PER_BIT(CPB),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .ser_load (ser_load),
        .ser_data (ser_data),
        .ser_shift(ser_shift),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Timeline model: a grant decided at edge t loads at t+1, shifts at load+k*CPB,
    // and the next decision is allowed at load+1+DW*CPB+GAP (or t+2 if the load was refused).
    int            m_rr, m_g, m_gt, m_lt, m_free;
    bit            m_pend, m_loaded;
    logic [NR-1:0] e_ready;
    logic          e_load, e_shift, e_busy;
    logic [DW-1:0] e_data;

    int load_cyc[$];
    int load_gid[$];
    int load_dat[$];
    int shift_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void model_edge();
        int k;
        if (rst) begin
            m_rr = 0; m_g = 0; m_pend = 0; m_loaded = 0;
            m_gt = cyc; m_free = cyc + 1; m_lt = cyc;
            e_ready = '0; e_load = 0; e_shift = 0; e_busy = 0; e_data = '0;
            return;
        end
        e_ready = '0; e_load = 0; e_shift = 0;
        if (m_pend && cyc == m_gt + 1) begin
            m_pend = 0;
            if (req_valid[m_g]) begin
                e_ready[m_g] = 1'b1;
                e_load       = 1'b1;
                e_data       = req_data[m_g*DW +: DW];
                m_rr         = (m_g + 1) % NR;
                m_loaded     = 1;
                m_lt         = cyc;
                m_free       = cyc + 1 + DW*CPB + GAP;
            end else begin
                m_free = cyc + 1;
            end
        end
        if (m_loaded && cyc > m_lt && (cyc - m_lt) % CPB == 0 && (cyc - m_lt) / CPB <= DW)
            e_shift = 1'b1;
        e_busy = (cyc > m_gt) && (cyc < m_free);
        if (!m_pend && cyc >= m_free && en && (req_valid != '0)) begin
            for (int i = 0; i < NR; i++) begin
                k = (m_rr + i) % NR;
                if (!m_pend && req_valid[k]) begin
                    m_g = k; m_gt = cyc; m_pend = 1;
                end
            end
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("req_ready", req_ready, e_ready);
        check("ser_load", ser_load, e_load);
        check("ser_shift", ser_shift, e_shift);
        check("busy", busy, e_busy);
        check("grant_id", grant_id, m_g);
        if (e_load || rst) check("ser_data", ser_data, e_data);
        if (ser_load) begin
            load_cyc.push_back(cyc);
            load_gid.push_back(int'(grant_id));
            load_dat.push_back(int'(ser_data));
        end
        if (ser_shift) shift_cyc.push_back(cyc);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_obs();
        load_cyc.delete(); load_gid.delete(); load_dat.delete(); shift_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic set_word(input int i, input logic [DW-1:0] w);
        req_data[i*DW +: DW] = w;
    endtask

    task automatic wait_load(input string tag, input int bound);
        int n = 0;
        tick();
        while (!ser_load && n < bound) begin
            tick();
            n++;
        end
        check(tag, ser_load, 1'b1);
    endtask

    int t0;
    int r0;
    int nsh;

    initial begin
        // Reset values
        do_reset();
        check("rst_ready", req_ready, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", ser_data, '0);

        // Single requester: load at +1, shifts +5..+33, held valid reloads at +37
        en = 1'b1;
        set_word(0, 8'hA5);
        req_valid = 4'b0001;
        t0 = cyc;
        run(40);
        check("t1_loads", load_cyc.size(), 2);
        check("t1_shifts", shift_cyc.size(), 8);
        if (load_cyc.size() >= 2) begin
            check("t1_load0_at", load_cyc[0] - t0, 1);
            check("t1_load1_at", load_cyc[1] - t0, 37);
            check("t1_data", load_dat[0], 32'hA5);
            check("t1_gid", load_gid[1], 0);
        end
        if (shift_cyc.size() == 8) begin
            check("t1_first_shift", shift_cyc[0] - t0, 5);
            check("t1_last_shift", shift_cyc[7] - t0, 33);
        end

        // All four requesters continuously valid: order 0,1,2,3,0 every 36 cycles
        do_reset();
        for (int i = 0; i < NR; i++) set_word(i, 8'h10 + 8'(i));
        req_valid = 4'b1111;
        t0 = cyc;
        run(150);
        check("t2_loads", load_cyc.size(), 5);
        if (load_cyc.size() == 5) begin
            check("t2_first_at", load_cyc[0] - t0, 1);
            for (int i = 0; i < 5; i++) begin
                check("t2_gid", load_gid[i], i % NR);
                check("t2_data", load_dat[i], 32'h10 + (i % NR));
                if (i > 0) check("t2_spacing", load_cyc[i] - load_cyc[i-1], 36);
            end
        end

        // Requester 2 served, then only 0 and 3 valid -> 3 then 0
        do_reset();
        set_word(2, 8'h22);
        req_valid = 4'b0100;
        wait_load("t3_wait_load", 10);
        set_word(0, 8'h30);
        set_word(3, 8'h33);
        req_valid = 4'b1001;
        run(80);
        check("t3_loads", load_gid.size(), 3);
        if (load_gid.size() == 3) begin
            check("t3_gid0", load_gid[0], 2);
            check("t3_gid1", load_gid[1], 3);
            check("t3_gid2", load_gid[2], 0);
            check("t3_data1", load_dat[1], 32'h33);
        end

        // Requester 1 granted, withdraws before LOAD; rr_ptr stays at 0
        do_reset();
        set_word(1, 8'h5A);
        req_valid = 4'b0010;
        tick();
        check("t4_granted", grant_id, 1);
        req_valid = 4'b0000;
        tick();
        check("t4_no_load", ser_load, 1'b0);
        check("t4_no_ready", req_ready, '0);
        run(3);
        check("t4_idle", busy, 1'b0);
        req_valid = 4'b1001;
        wait_load("t4_wait_load", 10);
        check("t4_loads", load_gid.size(), 1);
        if (load_gid.size() == 1) check("t4_rr_unchanged", load_gid[0], 0);

        // Reset at the third shift aborts the frame and rewinds rr_ptr
        do_reset();
        set_word(0, 8'hA5);
        set_word(1, 8'hB6);
        req_valid = 4'b0001;
        nsh = 0;
        while (shift_cyc.size() < 3 && nsh < 40) begin
            tick();
            nsh++;
        end
        check("t5_three_shifts", shift_cyc.size(), 3);
        clear_obs();
        rst = 1'b1;
        r0 = cyc;
        tick();
        rst = 1'b0;
        check("t5_rst_shift", ser_shift, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_gid", grant_id, 0);
        req_valid = 4'b0011;
        run(5);
        check("t5_no_old_shifts", shift_cyc.size(), 0);
        check("t5_reload", load_gid.size(), 1);
        if (load_gid.size() == 1) begin
            check("t5_gid_from_0", load_gid[0], 0);
            check("t5_reload_at", load_cyc[0] - r0, 2);
        end

        // en low blocks grants; dropping en mid-frame lets the frame finish
        do_reset();
        en = 1'b0;
        for (int i = 0; i < NR; i++) set_word(i, 8'hC0 + 8'(i));
        req_valid = 4'b1111;
        run(20);
        check("t6_blocked", load_cyc.size(), 0);
        en = 1'b1;
        wait_load("t6_wait_load", 5);
        run(6);
        en = 1'b0;
        run(100);
        check("t6_single_frame", load_cyc.size(), 1);
        check("t6_shifts", shift_cyc.size(), 8);
        check("t6_idle", busy, 1'b0);
        en = 1'b1;
        wait_load("t6_resume", 5);
        check("t6_loads", load_cyc.size(), 2);

        // Random traffic
        do_reset();
        en = 1'b1;
        req_valid = '0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i]) begin
                    if (req_ready[i]) begin
                        req_valid[i] = ($urandom_range(0, 2) == 0);
                        set_word(i, 8'($urandom));
                    end else if ($urandom_range(0, 199) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b1;
                    set_word(i, 8'($urandom));
                end
            end
        end
        rst = 1'b0;
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/srlzr_tx_sched.md
Name: srlzr_tx_sched

Overview:
- Round-robin scheduler that shares one PISO serializer among NUM_REQ byte sources in the transceiver TX path.
- Selects a requester, accepts its word through a valid/ready handshake and pulses the serializer load.
- Paces DATA_WIDTH shift pulses at CLKS_PER_BIT clocks per bit, then enforces an inter-frame gap before the next grant.

Parameters:
- DATA_WIDTH, 8: width of one word and number of shift pulses per frame.
- NUM_REQ, 4: number of requesters; range 2..16.
- CLKS_PER_BIT, 4: clocks per serial bit; minimum 1.
- GAP_CYCLES, 2: idle cycles after each frame; minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  high = new grants allowed; a frame in progress always completes.
- req_valid  in  NUM_REQ  per-requester word available.
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot, 1-cycle acceptance pulse.
- ser_load  out  1  1-cycle load strobe to the serializer.
- ser_data  out  DATA_WIDTH  word for the serializer; valid when ser_load = 1.
- ser_shift  out  1  1-cycle shift strobe, once per bit.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high in LOAD, SHIFT and GAP.

Behaviour:
- All outputs are registered.
- Reset: state IDLE, rr_ptr = 0, all counters = 0, req_ready = 0, ser_load = 0, ser_shift = 0, ser_data = 0, grant_id = 0, busy = 0. A reset mid-frame aborts the frame immediately; no further ser_shift pulses follow.
- IDLE:
  - If en = 1 and any req_valid = 1, choose the first asserted index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register the choice in grant_id; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - If req_valid[grant_id] is still 1: req_ready[grant_id] = 1, ser_load = 1, ser_data = req_data[grant_id], rr_ptr = (grant_id + 1) mod NUM_REQ; go to SHIFT.
  - If req_valid[grant_id] has dropped: no ready, no load, rr_ptr unchanged; return to IDLE.
- Requesters hold valid and data stable from assertion until the ready pulse.
- SHIFT:
  - The baud counter counts 0..CLKS_PER_BIT-1. ser_shift = 1 in the cycle the counter equals CLKS_PER_BIT-1, and the bit counter then increments.
  - After the DATA_WIDTH-th shift pulse, go to GAP.
- GAP: hold GAP_CYCLES cycles with no strobes, then go to IDLE.
- Timing, with the grant decision in IDLE at cycle t:
  - LOAD occurs at t+1.
  - Shift pulses occur at t+1+k*CLKS_PER_BIT for k = 1..DATA_WIDTH.
  - GAP spans t+2+DATA_WIDTH*CLKS_PER_BIT for GAP_CYCLES cycles.
  - The earliest next ser_load is at t+3+DATA_WIDTH*CLKS_PER_BIT+GAP_CYCLES.
- Boundary and concurrency rules:
  - Valid inputs arriving during LOAD, SHIFT or GAP are ignored until IDLE.
  - en falling mid-frame does not affect the current frame.
  - When only one requester is valid, it is granted repeatedly.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - req_ready and ser_load are never asserted outside LOAD.
  - At most one req_ready bit is high in any cycle.

Test Plan:
- Reset, then req_valid = 4'b0001 with data 0xA5 at cycle 0 (defaults) -> ser_load and req_ready[0] at cycle 1 with ser_data = 0xA5; ser_shift at cycles 5, 9, ..., 33 (8 pulses); busy low at cycle 36; a held valid gives the next load at 37.
- All four requesters valid continuously with data 0x10..0x13 -> grant order 0,1,2,3,0, ser_data 0x10,0x11,0x12,0x13,0x10, loads spaced 36 cycles apart.
- Requester 2 already granted, then only requesters 0 and 3 valid -> order 3 then 0 (wrap).
- Requester 1 granted in IDLE but drops valid before LOAD -> no req_ready, no ser_load; back to IDLE; rr_ptr unchanged; next grant re-evaluated.
- rst asserted at the 3rd ser_shift -> following cycle all outputs 0, no further shifts, grant_id = 0; the next grant starts from requester 0.
- en = 0 with requests pending -> no load; en deasserted during SHIFT -> frame completes with 8 shifts, then no new grant until en = 1.
